// File: rtl/riscv_mc_pkg.sv
// Shared constants for the multicycle RISC-V controller: opcodes, FSM states, select encodings.
// Pure definitions, no timing; the control-word struct carries the per-state Moore outputs.
package riscv_mc_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
  } state_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       pc_update;
    logic       branch;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_output_decoder.sv
// Combinational state -> control-word table; zero latency.
// mem_ready only gates the FETCH-side IR/PC enables, nothing here stalls.
module mc_output_decoder
  import riscv_mc_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_write   = mem_ready;
        ctrl.pc_update  = mem_ready;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURESULT;
      end
      // branch target is precomputed from OldPC + imm while decoding
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD:  ctrl.adr_src = 1'b1;
      S_MEMWRITE: begin
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
      end
      S_EXECUTER: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.branch    = 1'b1;
      end
      S_JAL: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_update = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: one state per cycle, CPI 2..5 with outputs Moore except PCWrite/ImmSrc.
// Stalls in FETCH/MEMREAD/MEMWRITE until mem_ready; reset gates all write enables immediately.
module multicycle_controller
  import riscv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       illegal_op
);

  state_t state_q, state_d;
  ctrl_t  ctrl;
  logic   illegal_dec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    illegal_dec = 1'b0;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d     = S_FETCH;
            illegal_dec = 1'b1;
          end
        endcase
      end
      // only lw/sw reach MEMADR, so anything not lw must be sw
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_MEMWB, S_BEQ, S_ALUWB:      state_d = S_FETCH;
      S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  mc_output_decoder u_dec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // enables are gated by rst directly so they drop before any clock edge
  assign PCWrite    = rst & (ctrl.pc_update | (ctrl.branch & zero));
  assign IRWrite    = rst & ctrl.ir_write;
  assign MemWrite   = rst & ctrl.mem_write;
  assign RegWrite   = rst & ctrl.reg_write;
  assign illegal_op = rst & illegal_dec;
  assign AdrSrc     = ctrl.adr_src;
  assign ResultSrc  = ctrl.result_src;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign ALUOp      = ctrl.alu_op;
  assign ImmSrc     = imm_src_of(op);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed vector bench for multicycle_controller: per-cycle control-word table plus an async-reset sequence.
module tb_multicycle_controller;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct packed {
    logic [63:0] tag;
    logic        rst_n;
    logic [6:0]  op;
    logic        zero;
    logic        rdy;
    logic [15:0] exp;
  } vec_t;

  logic       clk, rst_n, zero, mem_ready;
  logic [6:0] op;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;

  vec_t vq[$];
  int   passed = 0;
  int   total  = 0;

  multicycle_controller dut (
    .clk(clk), .rst(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // word layout: PCWrite AdrSrc MemWrite IRWrite ResultSrc ALUSrcA ALUSrcB ALUOp ImmSrc RegWrite illegal_op
  function automatic logic [15:0] mk(input logic pcw, adr, mw, irw,
                                     input logic [1:0] rs, sa, sb, aop, imm,
                                     input logic rw, ill);
    return {pcw, adr, mw, irw, rs, sa, sb, aop, imm, rw, ill};
  endfunction

  function automatic logic [15:0] w_fetch(input logic r, input logic [1:0] imm);
    return mk(r, 0, 0, r, 2'b10, 2'b00, 2'b10, 2'b00, imm, 0, 0);
  endfunction
  function automatic logic [15:0] w_rst(input logic [1:0] imm);
    return mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, imm, 0, 0);
  endfunction
  function automatic logic [15:0] w_dec(input logic [1:0] imm, input logic ill);
    return mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, imm, 0, ill);
  endfunction
  function automatic logic [15:0] w_aluwb(input logic [1:0] imm);
    return mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm, 1, 0);
  endfunction

  wire [15:0] got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                     ALUSrcB, ALUOp, ImmSrc, RegWrite, illegal_op};

  task automatic add(input logic [63:0] tag, input logic r, input logic [6:0] o,
                     input logic z, input logic rdy, input logic [15:0] e);
    vec_t v;
    v.tag = tag; v.rst_n = r; v.op = o; v.zero = z; v.rdy = rdy; v.exp = e;
    vq.push_back(v);
  endtask

  task automatic check(input logic [63:0] tag, input logic [15:0] e);
    total++;
    if (got === e) passed++;
    else $display("FAIL %s: got %b expected %b", tag, got, e);
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    rst_n = v.rst_n; op = v.op; zero = v.zero; mem_ready = v.rdy;
    #1;
    check(v.tag, v.exp);
  endtask

  initial begin
    rst_n = 1'b0; op = LW; zero = 1'b0; mem_ready = 1'b1;

    add("rst0", 0, LW, 0, 1, w_rst(2'b00));
    add("rst1", 0, LW, 0, 1, w_rst(2'b00));
    // lw, 5 cycles
    add("lwFET", 1, LW, 0, 1, w_fetch(1, 2'b00));
    add("lwDEC", 1, LW, 0, 1, w_dec(2'b00, 0));
    add("lwADR", 1, LW, 0, 1, mk(0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 2'b00, 0,0));
    add("lwRD",  1, LW, 0, 1, mk(0,1,0,0, 2'b00,2'b00,2'b00,2'b00, 2'b00, 0,0));
    add("lwWB",  1, LW, 0, 1, mk(0,0,0,0, 2'b01,2'b00,2'b00,2'b00, 2'b00, 1,0));
    // beq taken, then not taken
    add("bqFET1", 1, BEQ, 1, 1, w_fetch(1, 2'b10));
    add("bqDEC1", 1, BEQ, 1, 1, w_dec(2'b10, 0));
    add("bqEXE1", 1, BEQ, 1, 1, mk(1,0,0,0, 2'b00,2'b10,2'b00,2'b01, 2'b10, 0,0));
    add("bqFET0", 1, BEQ, 0, 1, w_fetch(1, 2'b10));
    add("bqDEC0", 1, BEQ, 0, 1, w_dec(2'b10, 0));
    add("bqEXE0", 1, BEQ, 0, 1, mk(0,0,0,0, 2'b00,2'b10,2'b00,2'b01, 2'b10, 0,0));
    // sw with three not-ready cycles in MEMWRITE
    add("swFET", 1, SW, 0, 1, w_fetch(1, 2'b01));
    add("swDEC", 1, SW, 0, 1, w_dec(2'b01, 0));
    add("swADR", 1, SW, 0, 1, mk(0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 2'b01, 0,0));
    for (int i = 0; i < 3; i++)
      add("swWAIT", 1, SW, 0, 0, mk(0,1,1,0, 2'b00,2'b00,2'b00,2'b00, 2'b01, 0,0));
    add("swRDY", 1, SW, 0, 1, mk(0,1,1,0, 2'b00,2'b00,2'b00,2'b00, 2'b01, 0,0));
    // R-type with two-cycle fetch stall; zero high must not matter
    add("rFSTL0", 1, RT, 1, 0, w_fetch(0, 2'b00));
    add("rFSTL1", 1, RT, 1, 0, w_fetch(0, 2'b00));
    add("rFET",   1, RT, 1, 1, w_fetch(1, 2'b00));
    add("rDEC",   1, RT, 1, 0, w_dec(2'b00, 0));
    add("rEXE",   1, RT, 1, 0, mk(0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 2'b00, 0,0));
    add("rWB",    1, RT, 1, 0, w_aluwb(2'b00));
    // I-type, ready ignored outside memory states
    add("iFET", 1, IT, 0, 1, w_fetch(1, 2'b00));
    add("iDEC", 1, IT, 0, 0, w_dec(2'b00, 0));
    add("iEXE", 1, IT, 0, 0, mk(0,0,0,0, 2'b00,2'b10,2'b01,2'b10, 2'b00, 0,0));
    add("iWB",  1, IT, 0, 0, w_aluwb(2'b00));
    // jal
    add("jFET", 1, JAL, 0, 1, w_fetch(1, 2'b11));
    add("jDEC", 1, JAL, 0, 1, w_dec(2'b11, 0));
    add("jEXE", 1, JAL, 0, 0, mk(1,0,0,0, 2'b00,2'b01,2'b10,2'b00, 2'b11, 0,0));
    add("jWB",  1, JAL, 0, 1, w_aluwb(2'b11));
    // illegal opcode: one-cycle flag, straight back to FETCH
    add("xFET",  1, BAD, 1, 1, w_fetch(1, 2'b00));
    add("xDEC",  1, BAD, 1, 1, w_dec(2'b00, 1));
    add("xFET2", 1, BAD, 1, 0, w_fetch(0, 2'b00));

    foreach (vq[i]) run_vec(vq[i]);

    // lw into MEMREAD, then asynchronous reset mid-cycle
    vq.delete();
    add("arFET", 1, LW, 0, 1, w_fetch(1, 2'b00));
    add("arDEC", 1, LW, 0, 1, w_dec(2'b00, 0));
    add("arADR", 1, LW, 0, 1, mk(0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 2'b00, 0,0));
    add("arRD",  1, LW, 0, 1, mk(0,1,0,0, 2'b00,2'b00,2'b00,2'b00, 2'b00, 0,0));
    foreach (vq[i]) run_vec(vq[i]);
    #1 rst_n = 1'b0;
    #1 check("arAsync", w_rst(2'b00));

    vq.delete();
    add("arHold", 0, RT, 0, 1, w_rst(2'b00));
    add("arRFET", 1, RT, 0, 1, w_fetch(1, 2'b00));
    add("arRDEC", 1, RT, 0, 1, w_dec(2'b00, 0));
    add("arREXE", 1, RT, 0, 1, mk(0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 2'b00, 0,0));
    add("arRWB",  1, RT, 0, 1, w_aluwb(2'b00));
    add("arNEXT", 1, RT, 0, 1, w_fetch(1, 2'b00));
    foreach (vq[i]) run_vec(vq[i]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle RISC-V core: sequences a shared datapath (one memory for instructions and data, one ALU, holding registers) through fetch, decode, execute, memory and writeback steps. It replaces the single-cycle combinational decode path with a state machine. It drives all datapath mux selects and write enables from the current state, the instruction opcode and the ALU zero flag, and stalls on a memory-ready handshake.

## Interface
- No parameters; opcodes and encodings are package constants.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- op  in  7  opcode of the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has accepted/returned the current access
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction register and OldPC enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A (rs1)
- ALUSrcB  out  2  00 B (rs2), 01 ImmExt, 10 constant 4
- ALUOp  out  2  00 add, 01 subtract (branch), 10 funct-decoded
- ImmSrc  out  2  00 I-type, 01 S-type, 10 B-type, 11 J-type
- RegWrite  out  1  register file write enable
- illegal_op  out  1  unrecognised opcode in DECODE

## Operation
- Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- Transitions:
  - FETCH → DECODE when mem_ready; otherwise hold.
  - DECODE → MEMADR for lw/sw, EXECUTER for R, EXECUTEI for I-ALU, BEQ for beq, JAL for jal. Any other op → FETCH with illegal_op=1 for that cycle.
  - MEMADR → MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD → MEMWB when mem_ready; otherwise hold.
  - MEMWRITE → FETCH when mem_ready; otherwise hold.
  - MEMWB → FETCH. BEQ → FETCH.
  - EXECUTER, EXECUTEI, JAL → ALUWB. ALUWB → FETCH.
- Moore outputs per state; unlisted signals are 0/00:
  - FETCH: AdrSrc=0, IRWrite=mem_ready, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, PCUpdate=mem_ready.
  - DECODE: ALUSrcA=01, ALUSrcB=01 (branch target precomputed).
  - MEMADR: ALUSrcA=10, ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1 (held for the whole wait).
  - MEMWB: ResultSrc=01, RegWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
- PCWrite = PCUpdate | (Branch & zero), combinational.
- ImmSrc is combinational from op in every state: lw/I 00, sw 01, beq 10, jal 11, others 00.

## Timing
- State register updates on rising clk. rst=0 forces FETCH immediately (asynchronous).
- While rst=0, PCWrite, IRWrite, MemWrite, RegWrite and illegal_op are forced 0. Selects take FETCH values.
- A fetch in progress when reset asserts is abandoned. After release, the FSM restarts in FETCH.
- CPI with mem_ready tied 1: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2. Each low cycle of mem_ready in FETCH/MEMREAD/MEMWRITE adds one cycle.
- zero is sampled only in BEQ, in the same cycle (combinational into PCWrite).
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.

## Structure
- Package riscv_mc_pkg: opcode constants, state enum, ResultSrc/ALUSrcA/ALUSrcB/ALUOp/ImmSrc encodings.
- Sub-module mc_output_decoder: combinational state→control-word map. It is kept separate so verification can check the table in isolation. Next-state logic and the state register stay in multicycle_controller.

## Test plan
- Reset, then ready tied 1, op=lw: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB over 5 cycles. RegWrite=1 only in cycle 5 with ResultSrc=01.
- op=beq: with zero=1, PCWrite=1 in cycle 3; with zero=0, PCWrite=0 in cycle 3. Return to FETCH in cycle 4.
- op=sw with mem_ready low for 3 cycles in MEMWRITE: MemWrite held 1 for 4 cycles, AdrSrc=1. FETCH follows the ready cycle.
- mem_ready=0 for 2 cycles in FETCH: IRWrite=PCWrite=0 for those cycles, then a 1-cycle pulse of both. DECODE follows.
- op=7'b1111111: illegal_op=1 in DECODE only, next state FETCH, no write enables asserted.
- rst pulled low during MEMREAD: state goes to FETCH asynchronously and all enables read 0 before the next clk edge. After release, an R-type instruction completes in 4 cycles with ALUOp=10.
